// File: rtl/alu_slice_sequencer_pkg.sv
// rtl/alu_slice_sequencer_pkg.sv - shared op, slice-control and state encodings (package alu_pkg)
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_XOR = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  // {S,V,R} slice control per op
  localparam logic [2:0] SVR_ADD = 3'b000;
  localparam logic [2:0] SVR_XOR = 3'b001;
  localparam logic [2:0] SVR_AND = 3'b100;
  localparam logic [2:0] SVR_OR  = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [2:0] svr_of(input logic [1:0] op);
    case (op)
      ALU_ADD: svr_of = SVR_ADD;
      ALU_XOR: svr_of = SVR_XOR;
      ALU_AND: svr_of = SVR_AND;
      default: svr_of = SVR_OR;
    endcase
  endfunction

  // AND seeds the chain with 1 so the slice carry reads back as set
  function automatic logic first_cy(input logic [1:0] op, input logic cin);
    case (op)
      ALU_ADD: first_cy = cin;
      ALU_AND: first_cy = 1'b1;
      default: first_cy = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_slice_sequencer_if.sv
// rtl/alu_slice_sequencer_if.sv - request/result bundle between decode and the sequencer
interface alu_slice_sequencer_if #(parameter int WIDTH = 8);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             half_carry;
  logic             flag_z;
  logic             flag_s;
  logic             flag_p;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, result, carry, half_carry, flag_z, flag_s, flag_p
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, result, carry, half_carry, flag_z, flag_s, flag_p
  );
endinterface

// File: rtl/alu_slice.sv
// rtl/alu_slice.sv - one-bit ALU slice: S selects logic ops, V picks OR over AND, R suppresses carry.
module alu_slice (
  input  logic op1,
  input  logic op2,
  input  logic cy_in,
  input  logic s,
  input  logic v,
  input  logic r,
  output logic res,
  output logic cy_out
);
  logic g;
  logic p;

  assign g = op1 & op2;
  assign p = op1 ^ op2;

  // logic ops pass the chain through untouched; R turns the adder into XOR
  assign res    = s ? (v ? (op1 | op2) : g) : (p ^ (cy_in & ~r));
  assign cy_out = s ? cy_in : (~r & (g | (p & cy_in)));
endmodule

// File: rtl/alu_slice_sequencer.sv
// rtl/alu_slice_sequencer.sv - bit-serial LSB-first driver for alu_slice with result/flag assembly.
// Optional flag logic enabled by ALU_SEQ_FLAGS_EN.
module alu_slice_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HBIT  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_slice_sequencer_if.slave bus
);
  localparam int IW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_full;
  logic [WIDTH-1:0] result_q;
  logic [1:0]       op_q;
  logic             cin_q;
  logic             cy_q;
  logic             carry_q;
  logic             hc_q;
  logic             accept;
  logic             last;
  logic [2:0]       svr;
  logic             bit_cy;
  logic             slice_res;
  logic             slice_cy;

  assign accept = bus.start && (state == IDLE || state == DONE);
  assign last   = (idx == IW'(WIDTH - 1));
  assign svr    = svr_of(op_q);
  assign bit_cy = (idx == '0) ? first_cy(op_q, cin_q) : cy_q;

  alu_slice u_slice (
    .op1    (a_q[idx]),
    .op2    (b_q[idx]),
    .cy_in  (bit_cy),
    .s      (svr[2]),
    .v      (svr[1]),
    .r      (svr[0]),
    .res    (slice_res),
    .cy_out (slice_cy)
  );

  always_comb begin
    shift_full      = shift_q;
    shift_full[idx] = slice_res;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      cy_q     <= 1'b0;
      shift_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      hc_q     <= 1'b0;
    end else if (accept) begin
      idx     <= '0;
      a_q     <= bus.a;
      b_q     <= bus.b;
      op_q    <= bus.op;
      cin_q   <= bus.cin;
      cy_q    <= 1'b0;
      shift_q <= '0;
    end else if (state == RUN) begin
      shift_q <= shift_full;
      cy_q    <= slice_cy;
      idx     <= idx + 1'b1;
      if (idx == IW'(HBIT)) hc_q <= slice_cy;
      if (last) begin
        result_q <= shift_full;
        carry_q  <= slice_cy;
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic flag_z_q;
  logic flag_s_q;
  logic flag_p_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_z_q <= 1'b0;
      flag_s_q <= 1'b0;
      flag_p_q <= 1'b0;
    end else if (state == RUN && last) begin
      flag_z_q <= (shift_full == '0);
      flag_s_q <= shift_full[WIDTH-1];
      flag_p_q <= ~^shift_full;
    end
  end

  assign bus.flag_z = flag_z_q;
  assign bus.flag_s = flag_s_q;
  assign bus.flag_p = flag_p_q;
`else
  assign bus.flag_z = 1'b0;
  assign bus.flag_s = 1'b0;
  assign bus.flag_p = 1'b0;
`endif

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.result     = result_q;
  assign bus.carry      = carry_q;
  assign bus.half_carry = hc_q;
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// tb/tb_alu_slice_sequencer.sv - vector table plus hand sequences for back-to-back, mid-run start and reset.
module tb_alu_slice_sequencer;
  import alu_pkg::*;

`ifdef ALU_SEQ_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] r;
    logic       c;
    logic       h;
    logic       z;
    logic       s;
    logic       p;
  } vec_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_fail;
  vec_t vecs [8];

  alu_slice_sequencer_if #(.WIDTH(8)) bus ();

  alu_slice_sequencer #(.WIDTH(8), .HBIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    n_vec++;
  endtask

  // returns at the falling edge of the done cycle (or after the cycle budget)
  task automatic wait_done(output int lat, output int busy_c, output logic first_busy);
    lat        = 0;
    busy_c     = 0;
    first_busy = 1'b0;
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.start  = 1'b0;
        first_busy = bus.busy;
      end
      if (bus.busy) busy_c++;
    end while (!bus.done && lat < 20);
  endtask

  initial begin
    int   lat;
    int   busy_c;
    logic fb;
    logic done_seen;

    n_vec  = 0;
    n_fail = 0;
    vecs[0] = '{ALU_ADD, 8'h3A, 8'hC6, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{ALU_ADD, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{ALU_XOR, 8'hF0, 8'h3C, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{ALU_AND, 8'h0F, 8'hFF, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{ALU_OR,  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{ALU_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{ALU_OR,  8'h50, 8'h0A, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{ALU_ADD, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_carry", bus.carry, 0);
    check("rst_hc", bus.half_carry, 0);
    check("rst_flags", {bus.flag_z, bus.flag_s, bus.flag_p}, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(lat, busy_c, fb);
      check($sformatf("v%0d_latency", i), lat, 9);
      check($sformatf("v%0d_busy_cycles", i), busy_c, 8);
      check($sformatf("v%0d_result", i), bus.result, vecs[i].r);
      check($sformatf("v%0d_carry", i), bus.carry, vecs[i].c);
      check($sformatf("v%0d_half_carry", i), bus.half_carry, vecs[i].h);
      check($sformatf("v%0d_flag_z", i), bus.flag_z, vecs[i].z & FLAGS_ON);
      check($sformatf("v%0d_flag_s", i), bus.flag_s, vecs[i].s & FLAGS_ON);
      check($sformatf("v%0d_flag_p", i), bus.flag_p, vecs[i].p & FLAGS_ON);
      @(negedge clk);
      check($sformatf("v%0d_done_width", i), bus.done, 0);
      check($sformatf("v%0d_result_held", i), bus.result, vecs[i].r);
    end

    // back-to-back: second start presented during the done cycle
    @(negedge clk);
    launch(ALU_XOR, 8'hF0, 8'h3C, 1'b0);
    wait_done(lat, busy_c, fb);
    check("b2b_first_result", bus.result, 8'hCC);
    launch(ALU_AND, 8'h0F, 8'hFF, 1'b0);
    wait_done(lat, busy_c, fb);
    check("b2b_busy_next", fb, 1);
    check("b2b_latency", lat, 9);
    check("b2b_second_result", bus.result, 8'h0F);
    check("b2b_second_carry", bus.carry, 1);

    // start during RUN is ignored
    @(negedge clk);
    launch(ALU_ADD, 8'h3A, 8'hC6, 1'b0);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.start = 1'b0;
      if (lat == 3) begin
        bus.op    = ALU_OR;
        bus.a     = 8'h11;
        bus.b     = 8'h22;
        bus.start = 1'b1;
      end
      if (lat == 4) bus.start = 1'b0;
    end while (!bus.done && lat < 20);
    check("midstart_latency", lat, 9);
    check("midstart_result", bus.result, 8'h00);
    check("midstart_carry", bus.carry, 1);
    @(negedge clk);
    check("midstart_no_requeue", bus.busy, 0);

    // reset while the slice is on bit 4
    @(negedge clk);
    launch(ALU_ADD, 8'hFF, 8'h00, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("rstmid_busy_before", bus.busy, 1);
    reset = 1'b1;
    #1;
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_result", bus.result, 0);
    check("rstmid_carry", bus.carry, 0);
    check("rstmid_hc", bus.half_carry, 0);
    check("rstmid_flags", {bus.flag_z, bus.flag_s, bus.flag_p}, 0);
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
    check("rstmid_no_done", done_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_slice_sequencer.md
Name: alu_slice_sequencer

Overview:
Bit-serial controller that drives one `alu_slice` instance across an 8-bit operand, one bit per clock, LSB first.
- It latches operands and an operation code, then generates the slice control lines S/V/R.
- It chains the slice carry through a register between bits and assembles the 8-bit result and flags.
- It sits between the instruction decode/register file and the existing `alu_slice`, and is the driving end of the slice interface.

Parameters:
- WIDTH, 8, operand width in bits; number of RUN cycles.
- HBIT, 3, bit index whose slice carry-out is captured as half_carry.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  2  operation: 0=ADD, 1=XOR, 2=AND, 3=OR.
- a  in  WIDTH  operand driven to slice op1.
- b  in  WIDTH  operand driven to slice op2.
- cin  in  1  carry-in for ADD (ADC use); ignored for other ops.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a result is complete.
- result  out  WIDTH  assembled result; held until the next accepted start.
- carry  out  1  slice cy_out of the MSB.
- half_carry  out  1  slice cy_out of bit HBIT.
- flag_z  out  1  result == 0.
- flag_s  out  1  result[WIDTH-1].
- flag_p  out  1  even parity of result.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, carry=0, half_carry=0, all flags=0. Operand and shift registers are cleared.
- Slice control {S,V,R} from op:
  - ADD = 0,0,0; slice cy_in at bit 0 = latched cin.
  - XOR = 0,0,1; bit-0 cy_in = 0.
  - AND = 1,0,0; bit-0 cy_in = 1.
  - OR = 1,1,1; bit-0 cy_in = 0.
- Carry chain: for bits 1..WIDTH-1, slice cy_in = registered cy_out of the previous bit.
- States and transitions:
  - IDLE: start=1 latches a, b, op and cin, clears the bit index, and goes to RUN.
  - RUN: each cycle drives bit[idx] of both operands to the slice. On the edge it shifts the slice result into result bit idx and registers cy_out; at idx==HBIT it also captures half_carry. idx==WIDTH-1 goes to DONE; otherwise idx+1.
  - DONE: done=1 for exactly this cycle. carry and flags are valid from entry and held. start=1 here is accepted exactly as in IDLE (back-to-back ops, no idle gap). Otherwise go to IDLE.
- Latency: start accepted at edge N; busy high for cycles N+1..N+WIDTH; done high in cycle N+WIDTH+1.
- start while busy: ignored; no queuing. Inputs a/b/op/cin may change freely after acceptance.
- result, carry and flags update only at the end of RUN. During RUN, result holds the previous value; the shift uses an internal register.
- Reset mid-RUN: immediate return to the IDLE reset values; no done pulse.
- op is decoded from the latched copy only.

Optional Feature:
- Macro: ALU_SEQ_FLAGS_EN.
- Defined: flag_z, flag_s and flag_p are computed and registered at DONE entry.
- Undefined: the flag logic is omitted and the three flag outputs are tied 0. carry and half_carry remain present in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - the op encoding constants (ALU_ADD, ALU_XOR, ALU_AND, ALU_OR);
  - the SVR control constants per op;
  - state encoding IDLE/RUN/DONE.
- Instantiate the existing `alu_slice` as the single sub-module; no further sub-modules.

Test Plan:
- ADD a=0x3A, b=0xC6, cin=0 -> result=0x00, carry=1, half_carry=1, flag_z=1, flag_s=0, flag_p=1; done exactly 9 cycles after the start edge.
- ADD a=0xFF, b=0x00, cin=1 -> result=0x00, carry=1, half_carry=1.
- XOR a=0xF0, b=0x3C -> result=0xCC, carry=0, flag_s=1, flag_p=1. Same ops with the macro undefined -> flags=0.
- AND a=0x0F, b=0xFF -> result=0x0F, carry=1, half_carry=1.
- OR a=0x00, b=0x00 -> result=0x00, carry=0, flag_z=1. Back-to-back: start held during DONE -> next op accepted with busy rising the next cycle.
- Mid-op control:
  - Start during RUN with different operands -> ignored, first result unchanged.
  - Reset asserted at RUN bit 4 -> all outputs 0 immediately, no done pulse.
